// File: rtl/ps2_scancode_decoder_if.sv
// Bundle between the PS/2 receiver, the scan-code decoder and the character
// consumer. The master side drives scan bytes and FIFO controls; the slave is the decoder.
interface ps2_scancode_decoder_if;
  logic [7:0] scan_data;
  logic       scan_valid;
  logic       rd_en;
  logic       clear_overflow;
  logic [7:0] ascii_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic       overflow;
  logic       shift_active;
  logic       caps_lock;

  modport master (
    output scan_data, scan_valid, rd_en, clear_overflow,
    input  ascii_data, fifo_empty, fifo_full, overflow, shift_active, caps_lock
  );

  modport slave (
    input  scan_data, scan_valid, rd_en, clear_overflow,
    output ascii_data, fifo_empty, fifo_full, overflow, shift_active, caps_lock
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code to ASCII translator with make/break/extended prefix tracking,
// Shift/Caps-Lock state and a first-word-fall-through character FIFO.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input logic                  clock,
  input logic                  resetn,
  ps2_scancode_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREAK,
    ST_EXT,
    ST_EXT_BREAK
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR   = ADDR_W'(1);

  state_t            state_reg, state_next;
  logic              shift_reg, shift_next;
  logic              caps_reg, caps_next;
  logic              push;
  logic [7:0]        push_char;
  logic [7:0]        upper_char;
  logic [7:0]        direct_char;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              overflow_reg;
  logic              fifo_empty, fifo_full, pop, do_write, ovf_set;

  // Letter lookup yields the uppercase code; zero means "not a letter".
  always_comb begin
    upper_char = 8'h00;
    case (bus.scan_data)
      8'h1C: upper_char = 8'h41;  8'h32: upper_char = 8'h42;
      8'h21: upper_char = 8'h43;  8'h23: upper_char = 8'h44;
      8'h24: upper_char = 8'h45;  8'h2B: upper_char = 8'h46;
      8'h34: upper_char = 8'h47;  8'h33: upper_char = 8'h48;
      8'h43: upper_char = 8'h49;  8'h3B: upper_char = 8'h4A;
      8'h42: upper_char = 8'h4B;  8'h4B: upper_char = 8'h4C;
      8'h3A: upper_char = 8'h4D;  8'h31: upper_char = 8'h4E;
      8'h44: upper_char = 8'h4F;  8'h4D: upper_char = 8'h50;
      8'h15: upper_char = 8'h51;  8'h2D: upper_char = 8'h52;
      8'h1B: upper_char = 8'h53;  8'h2C: upper_char = 8'h54;
      8'h3C: upper_char = 8'h55;  8'h2A: upper_char = 8'h56;
      8'h1D: upper_char = 8'h57;  8'h22: upper_char = 8'h58;
      8'h35: upper_char = 8'h59;  8'h1A: upper_char = 8'h5A;
      default: upper_char = 8'h00;
    endcase
  end

  // Digits and specials ignore modifiers; every valid code here is nonzero.
  always_comb begin
    direct_char = 8'h00;
    case (bus.scan_data)
      8'h45: direct_char = 8'h30;  8'h16: direct_char = 8'h31;
      8'h1E: direct_char = 8'h32;  8'h26: direct_char = 8'h33;
      8'h25: direct_char = 8'h34;  8'h2E: direct_char = 8'h35;
      8'h36: direct_char = 8'h36;  8'h3D: direct_char = 8'h37;
      8'h3E: direct_char = 8'h38;  8'h46: direct_char = 8'h39;
      8'h29: direct_char = 8'h20;  8'h5A: direct_char = 8'h0D;
      8'h66: direct_char = 8'h08;
      default: direct_char = 8'h00;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    caps_next  = caps_reg;
    push       = 1'b0;
    push_char  = 8'h00;
    if (bus.scan_valid) begin
      case (state_reg)
        ST_IDLE: begin
          case (bus.scan_data)
            8'hF0: state_next = ST_BREAK;
            8'hE0: state_next = ST_EXT;
            8'h12, 8'h59: shift_next = 1'b1;
            8'h58: caps_next = ~caps_reg;
            default: begin
              if (upper_char != 8'h00) begin
                push      = 1'b1;
                push_char = (shift_reg ^ caps_reg) ? upper_char : upper_char + 8'h20;
              end else if (direct_char != 8'h00) begin
                push      = 1'b1;
                push_char = direct_char;
              end
            end
          endcase
        end
        ST_BREAK: begin
          if (bus.scan_data == 8'h12 || bus.scan_data == 8'h59) shift_next = 1'b0;
          state_next = ST_IDLE;
        end
        // Extended makes (arrows, E0 12 fake shift) carry no character.
        ST_EXT: state_next = (bus.scan_data == 8'hF0) ? ST_EXT_BREAK : ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      shift_reg <= 1'b0;
      caps_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      caps_reg  <= caps_next;
    end
  end

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == DEPTH_CNT);
  assign pop        = bus.rd_en && !fifo_empty;
  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_write   = push && (!fifo_full || pop);
  assign ovf_set    = push && fifo_full && !pop;

  always_ff @(posedge clock) begin
    if (do_write) mem[wr_ptr_reg] <= push_char;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_write) wr_ptr_reg <= wr_ptr_reg + ONE_PTR;
      if (pop)      rd_ptr_reg <= rd_ptr_reg + ONE_PTR;
      if (do_write && !pop)      count_reg <= count_reg + ONE_CNT;
      else if (!do_write && pop) count_reg <= count_reg - ONE_CNT;
      if (ovf_set)                 overflow_reg <= 1'b1;
      else if (bus.clear_overflow) overflow_reg <= 1'b0;
    end
  end

  assign bus.ascii_data   = fifo_empty ? 8'h00 : mem[rd_ptr_reg];
  assign bus.fifo_empty   = fifo_empty;
  assign bus.fifo_full    = fifo_full;
  assign bus.overflow     = overflow_reg;
  assign bus.shift_active = shift_reg;
  assign bus.caps_lock    = caps_reg;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: scan-code sequences with
// hand-computed ASCII, flag and FIFO expectations.
module tb_ps2_scancode_decoder;

  logic clock;
  logic resetn;
  int   vec_count;
  int   miss_count;

  ps2_scancode_decoder_if bus ();

  ps2_scancode_decoder #(.FIFO_DEPTH(8), .ADDR_W(3)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // One clock of stimulus; returns 1 time unit after the edge that consumed it.
  task automatic drive(input logic [7:0] b, input logic v, input logic rd, input logic clr);
    bus.scan_data      = b;
    bus.scan_valid     = v;
    bus.rd_en          = rd;
    bus.clear_overflow = clr;
    @(posedge clock);
    #1;
    bus.scan_valid     = 1'b0;
    bus.rd_en          = 1'b0;
    bus.clear_overflow = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive(b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] expected);
    check(tag, {24'h0, bus.ascii_data}, {24'h0, expected});
    check({tag, "_nempty"}, {31'h0, bus.fifo_empty}, 32'd0);
    drive(8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ascii"}, {24'h0, bus.ascii_data}, 32'h0);
    check({tag, "_empty"}, {31'h0, bus.fifo_empty}, 32'd1);
    check({tag, "_full"},  {31'h0, bus.fifo_full},  32'd0);
    check({tag, "_ovf"},   {31'h0, bus.overflow},   32'd0);
    check({tag, "_shift"}, {31'h0, bus.shift_active}, 32'd0);
    check({tag, "_caps"},  {31'h0, bus.caps_lock},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_count          = 0;
    miss_count         = 0;
    resetn             = 1'b0;
    bus.scan_data      = 8'h00;
    bus.scan_valid     = 1'b0;
    bus.rd_en          = 1'b0;
    bus.clear_overflow = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_state("rst");
    resetn = 1'b1;

    // Lowercase make, break ignored, one-cycle latency, pop to empty.
    send(8'h1C);
    check("t1_a", {24'h0, bus.ascii_data}, 32'h61);
    check("t1_nempty", {31'h0, bus.fifo_empty}, 32'd0);
    send(8'hF0);
    send(8'h1C);
    pop_expect("t1_pop", 8'h61);
    check("t1_empty", {31'h0, bus.fifo_empty}, 32'd1);
    check("t1_zero", {24'h0, bus.ascii_data}, 32'h0);

    // Shift held across a letter, then released.
    send(8'h12);
    check("t2_shift_on", {31'h0, bus.shift_active}, 32'd1);
    send(8'h1C);
    send(8'hF0);
    check("t2_shift_hold", {31'h0, bus.shift_active}, 32'd1);
    send(8'h12);
    check("t2_shift_off", {31'h0, bus.shift_active}, 32'd0);
    send(8'h1C);
    pop_expect("t2_A", 8'h41);
    pop_expect("t2_a", 8'h61);
    check("t2_empty", {31'h0, bus.fifo_empty}, 32'd1);

    // Caps-Lock toggle, Shift cancelling Caps, digits unaffected.
    send(8'h58);
    check("t3_caps", {31'h0, bus.caps_lock}, 32'd1);
    send(8'hF0);
    send(8'h58);
    check("t3_caps_brk", {31'h0, bus.caps_lock}, 32'd1);
    send(8'h1C);
    send(8'h12);
    send(8'h1C);
    send(8'h16);
    pop_expect("t3_A", 8'h41);
    pop_expect("t3_a", 8'h61);
    pop_expect("t3_1", 8'h31);
    check("t3_empty", {31'h0, bus.fifo_empty}, 32'd1);
    send(8'hF0);
    send(8'h59 - 8'h47);
    check("t3_shift_off", {31'h0, bus.shift_active}, 32'd0);
    send(8'h58);
    check("t3_caps_off", {31'h0, bus.caps_lock}, 32'd0);

    // Extended codes produce nothing; E0 12 is not a shift.
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12);
    check("t4_noshift", {31'h0, bus.shift_active}, 32'd0);
    check("t4_none", {31'h0, bus.fifo_empty}, 32'd1);
    send(8'h29);
    pop_expect("t4_space", 8'h20);
    check("t4_empty", {31'h0, bus.fifo_empty}, 32'd1);

    // Fill, overflow, clear, set-beats-clear, push+pop while full.
    for (int i = 1; i <= 10; i++) begin
      send(8'h1C);
      if (i == 7) check("t5_notfull7", {31'h0, bus.fifo_full}, 32'd0);
      if (i == 8) begin
        check("t5_full8", {31'h0, bus.fifo_full}, 32'd1);
        check("t5_noovf8", {31'h0, bus.overflow}, 32'd0);
      end
      if (i == 9) check("t5_ovf9", {31'h0, bus.overflow}, 32'd1);
    end
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    check("t5_ovf_clr", {31'h0, bus.overflow}, 32'd0);
    drive(8'h1C, 1'b1, 1'b0, 1'b1);
    check("t5_set_wins", {31'h0, bus.overflow}, 32'd1);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    check("t5_ovf_clr2", {31'h0, bus.overflow}, 32'd0);
    drive(8'h1C, 1'b1, 1'b1, 1'b0);
    check("t5_pp_full", {31'h0, bus.fifo_full}, 32'd1);
    check("t5_pp_noovf", {31'h0, bus.overflow}, 32'd0);
    send(8'h12);
    drive(8'h1C, 1'b1, 1'b1, 1'b0);
    check("t5_pp2_full", {31'h0, bus.fifo_full}, 32'd1);
    for (int i = 0; i < 7; i++) pop_expect("t5_drain_a", 8'h61);
    pop_expect("t5_tail_A", 8'h41);
    check("t5_empty", {31'h0, bus.fifo_empty}, 32'd1);
    send(8'hF0);
    send(8'h12);

    // Push and pop together on an empty FIFO: only the push lands.
    drive(8'h29, 1'b1, 1'b1, 1'b0);
    pop_expect("t6_pp_empty", 8'h20);
    check("t6_empty", {31'h0, bus.fifo_empty}, 32'd1);

    // Asynchronous reset with pending break prefix and buffered data.
    send(8'h58);
    send(8'h12);
    send(8'h1C); send(8'h1C); send(8'h1C);
    check("t7_pre_nempty", {31'h0, bus.fifo_empty}, 32'd0);
    send(8'hF0);
    resetn = 1'b0;
    #2;
    check_reset_state("t7_rst");
    resetn = 1'b1;
    send(8'h1C);
    pop_expect("t7_after", 8'h61);
    check("t7_empty", {31'h0, bus.fifo_empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
